sd_block_read: RTL and testbench

Sequences the SD card's SPI byte-exchange engine to read one 512-byte block with CMD17 once card initialisation has finished. It accepts a request with a block address and issues the command bytes. It polls for the R1 response and then for the data start token, streams the 512 payload bytes to the consumer and consumes the CRC bytes. It sits between the system-side storage client and the byte engine that `sd_init` drives during bring-up, and it owns chip-select after `init_end`.

---
 rtl/sd_block_read.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sd_block_read.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_read.sv
// sd_block_read: reads one 512-byte SD block with CMD17 through an SPI byte-exchange engine.
// Optional CRC16 payload check is built when the macro SD_READ_CRC_EN is defined.
module sd_block_read #(
  parameter int R1_TIMEOUT    = 8,
  parameter int TOKEN_TIMEOUT = 4096,
  parameter int BYTE_ADDR     = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        init_end,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_busy,
  output logic        rd_done,
  output logic        rd_err,
  output logic [2:0]  err_code,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic [8:0]  dout_idx,
  output logic        sd_cs_n,
  output logic        xfer_start,
  output logic [7:0]  tx_byte,
  input  logic        xfer_done,
  input  logic [7:0]  rx_byte,
  output logic [2:0]  dbg_state
);

  // Byte engine handshake: xfer_start pulses once per byte and tx_byte is held until the
  // matching xfer_done pulse; rx_byte is only meaningful with xfer_done; one exchange at a time.
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TAIL, S_ERR
  } state_e;

  localparam logic [15:0] R1_LIM  = 16'(R1_TIMEOUT);
  localparam logic [15:0] TOK_LIM = 16'(TOKEN_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        xfer_start_q, xfer_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic [8:0]  dout_idx_q, dout_idx_d;

  logic        accept;
  logic        done_ev;
  logic        err_set;
  logic [2:0]  err_val;

  assign accept  = (state_q == S_IDLE) && init_end && rd_req;
  // A completion only counts while an exchange of ours is outstanding.
  assign done_ev = xfer_done && pend_q;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] a);
    case (idx)
      3'd0:    cmd_byte = 8'h51;
      3'd1:    cmd_byte = a[31:24];
      3'd2:    cmd_byte = a[23:16];
      3'd3:    cmd_byte = a[15:8];
      3'd4:    cmd_byte = a[7:0];
      default: cmd_byte = 8'hFF;
    endcase
  endfunction

`ifdef SD_READ_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_hi_q, crc_hi_d;
  logic        crc_ok;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_d    = crc_q;
    crc_hi_d = crc_hi_q;
    if (accept) begin
      crc_d = 16'h0000;
    end else if ((state_q == S_DATA) && done_ev) begin
      crc_d = crc16_byte(crc_q, rx_byte);
    end
    if ((state_q == S_CRC) && done_ev && (cnt_q == 16'd0)) begin
      crc_hi_d = rx_byte;
    end
  end

  assign crc_ok = ({crc_hi_q, rx_byte} == crc_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q    <= 16'h0000;
      crc_hi_q <= 8'h00;
    end else begin
      crc_q    <= crc_d;
      crc_hi_q <= crc_hi_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      pend_q       <= 1'b0;
      xfer_start_q <= 1'b0;
      tx_byte_q    <= 8'hFF;
      addr_q       <= 32'd0;
      err_code_q   <= 3'd0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      dout_idx_q   <= 9'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      xfer_start_q <= xfer_start_d;
      tx_byte_q    <= tx_byte_d;
      addr_q       <= addr_d;
      err_code_q   <= err_code_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_idx_q   <= dout_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    err_val = 3'd0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CMD;
      S_CMD:   if (done_ev && (cnt_q == 16'd5)) state_d = S_R1;
      S_R1: begin
        if (done_ev) begin
          if (rx_byte == 8'h00) begin
            state_d = S_TOKEN;
          end else if (!rx_byte[7]) begin
            state_d = S_ERR;
            err_set = 1'b1;
            err_val = 3'd2;
          end else if (cnt_q + 16'd1 == R1_LIM) begin
            state_d = S_ERR;
            err_set = 1'b1;
            err_val = 3'd1;
          end
        end
      end
      S_TOKEN: begin
        if (done_ev) begin
          if (rx_byte == 8'hFE) begin
            state_d = S_DATA;
          end else if (rx_byte[7:5] == 3'b000) begin
            state_d = S_ERR;
            err_set = 1'b1;
            err_val = 3'd3;
          end else if (cnt_q + 16'd1 == TOK_LIM) begin
            state_d = S_ERR;
            err_set = 1'b1;
            err_val = 3'd4;
          end
        end
      end
      S_DATA:  if (done_ev && (cnt_q == 16'd511)) state_d = S_CRC;
      S_CRC: begin
        if (done_ev && (cnt_q == 16'd1)) begin
`ifdef SD_READ_CRC_EN
          if (!crc_ok) begin
            state_d = S_ERR;
            err_set = 1'b1;
            err_val = 3'd5;
          end else begin
            state_d = S_TAIL;
          end
`else
          state_d = S_TAIL;
`endif
        end
      end
      S_TAIL:  if (done_ev) state_d = S_IDLE;
      S_ERR:   state_d = S_TAIL;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    xfer_start_d = 1'b0;
    tx_byte_d    = tx_byte_q;
    addr_d       = addr_q;
    err_code_d   = err_code_q;
    cs_n_d       = cs_n_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_idx_d   = dout_idx_q;

    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (done_ev) begin
      cnt_d = cnt_q + 16'd1;
    end

    // Launch on state entry (nothing outstanding) or back-to-back with the previous completion;
    // the error path launches the tail byte from the decision cycle, ERR just passes through.
    if ((state_q != S_IDLE) && (state_d != S_IDLE) && (done_ev || !pend_q)) begin
      xfer_start_d = 1'b1;
      pend_d       = 1'b1;
      tx_byte_d    = (state_d == S_CMD) ? cmd_byte(cnt_d[2:0], addr_q) : 8'hFF;
    end else if (done_ev) begin
      pend_d = 1'b0;
    end

    if (accept) begin
      addr_d     = (BYTE_ADDR != 0) ? {rd_addr[22:0], 9'd0} : rd_addr;
      err_code_d = 3'd0;
      cs_n_d     = 1'b0;
      busy_d     = 1'b1;
    end else if (done_q || err_q) begin
      busy_d = 1'b0;
    end

    if (err_set) err_code_d = err_val;

    if ((state_q == S_TAIL) && done_ev) begin
      cs_n_d = 1'b1;
      done_d = (err_code_q == 3'd0);
      err_d  = (err_code_q != 3'd0);
    end

    if ((state_q == S_DATA) && done_ev) begin
      dout_d       = rx_byte;
      dout_valid_d = 1'b1;
      dout_idx_d   = cnt_q[8:0];
    end
  end

  assign rd_busy    = busy_q;
  assign rd_done    = done_q;
  assign rd_err     = err_q;
  assign err_code   = err_code_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_idx   = dout_idx_q;
  assign sd_cs_n    = cs_n_q;
  assign xfer_start = xfer_start_q;
  assign tx_byte    = tx_byte_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sd_block_read.sv
// Bench for sd_block_read: scripted card responses, reference prediction of the read outcome,
// and checks on command bytes, payload stream, pulses and handshake timing.
module tb_sd_block_read;

  localparam int R1_TO  = 8;
  localparam int TOK_TO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        init_end;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_busy, rd_done, rd_err;
  logic [2:0]  err_code;
  logic [7:0]  dout;
  logic        dout_valid;
  logic [8:0]  dout_idx;
  logic        sd_cs_n, xfer_start;
  logic [7:0]  tx_byte;
  logic        xfer_done;
  logic [7:0]  rx_byte;
  logic [2:0]  dbg_state;

  sd_block_read #(.R1_TIMEOUT(R1_TO), .TOKEN_TIMEOUT(TOK_TO), .BYTE_ADDR(0)) dut (
    .CLK(CLK), .RST(RST), .init_end(init_end), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err), .err_code(err_code),
    .dout(dout), .dout_valid(dout_valid), .dout_idx(dout_idx), .sd_cs_n(sd_cs_n),
    .xfer_start(xfer_start), .tx_byte(tx_byte), .xfer_done(xfer_done), .rx_byte(rx_byte),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] resp [0:1023];
  int         rsp_i;
  logic [7:0] tx_log[$];
  logic [7:0] dout_log[$];
  logic [8:0] idx_log[$];
  logic [7:0] exp_q[$];
  int last_done_cyc, gap_err, hold_err;
  int done_cnt, err_cnt, pulse_bad;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Card / byte engine model: answers each launched exchange after 1..4 cycles.
  initial begin : card
    int lat;
    xfer_done = 1'b0;
    rx_byte   = 8'h00;
    forever begin
      @(negedge CLK);
      xfer_done = 1'b0;
      if (xfer_start === 1'b1 && RST === 1'b0) begin
        tx_log.push_back(tx_byte);
        if (last_done_cyc >= 0 && cyc != last_done_cyc + 1) gap_err++;
        lat = $urandom_range(1, 4);
        for (int k = 0; k < lat; k++) begin
          @(negedge CLK);
          if (tx_byte !== tx_log[$] || xfer_start === 1'b1) hold_err++;
        end
        rx_byte = (rsp_i < 1024) ? resp[rsp_i] : 8'hFF;
        rsp_i++;
        xfer_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (dout_valid === 1'b1) begin
        dout_log.push_back(dout);
        idx_log.push_back(dout_idx);
      end
      if (rd_done === 1'b1) begin
        done_cnt++;
        if (sd_cs_n !== 1'b1 || rd_busy !== 1'b1) pulse_bad++;
      end
      if (rd_err === 1'b1) begin
        err_cnt++;
        if (sd_cs_n !== 1'b1 || rd_busy !== 1'b1) pulse_bad++;
      end
      if (xfer_start === 1'b1 && sd_cs_n !== 1'b0) pulse_bad++;
    end
  end

  function automatic logic [15:0] ref_crc(input int start);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'h0000;
    for (int k = 0; k < 512; k++) begin
      b = resp[start + k];
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ b[j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic build(input int r1_polls, input logic [7:0] r1_val, input int tok_polls,
                       input logic [7:0] tok_val, input bit rand_data, input bit bad_crc);
    int i;
    logic [7:0]  b;
    logic [15:0] c;
    for (int k = 0; k < 1024; k++) resp[k] = 8'hFF;
    for (int k = 0; k < 6; k++) resp[k] = 8'($urandom);
    i = 6;
    for (int k = 0; k < r1_polls; k++) begin
      resp[i] = 8'h80 | 8'($urandom);
      i++;
    end
    resp[i] = r1_val;
    i++;
    for (int k = 0; k < tok_polls; k++) begin
      b = 8'($urandom_range(32, 255));
      if (b == 8'hFE) b = 8'hFF;
      resp[i] = b;
      i++;
    end
    resp[i] = tok_val;
    i++;
    if (tok_val == 8'hFE) begin
      for (int k = 0; k < 512; k++) resp[i + k] = rand_data ? 8'($urandom) : 8'(k);
      c = ref_crc(i);
      resp[i + 512] = c[15:8];
      resp[i + 513] = c[7:0] ^ (bad_crc ? 8'h01 : 8'h00);
    end
  endtask

  // Walks the response script with the protocol rules to get the expected outcome.
  task automatic predict(output int code, output int n_x, output int n_d);
    int i, polls;
    bit got;
    logic [7:0]  b;
    logic [15:0] rx_crc;
    exp_q.delete();
    code = 0; n_d = 0; i = 6;
    polls = 0; got = 0;
    while (!got && code == 0) begin
      b = resp[i]; i++;
      if (b == 8'h00) got = 1;
      else if (!b[7]) code = 2;
      else begin
        polls++;
        if (polls == R1_TO) code = 1;
      end
    end
    polls = 0; got = 0;
    while (!got && code == 0) begin
      b = resp[i]; i++;
      if (b == 8'hFE) got = 1;
      else if (b[7:5] == 3'b000) code = 3;
      else begin
        polls++;
        if (polls == TOK_TO) code = 4;
      end
    end
    if (code == 0) begin
      for (int k = 0; k < 512; k++) exp_q.push_back(resp[i + k]);
      n_d = 512;
      rx_crc = {resp[i + 512], resp[i + 513]};
`ifdef SD_READ_CRC_EN
      if (rx_crc != ref_crc(i)) code = 5;
`else
      if (rx_crc == 16'h0000) code = 0;
`endif
      i += 514;
    end
    n_x = i + 1;
  endtask

  task automatic clear_logs();
    tx_log.delete(); dout_log.delete(); idx_log.delete();
    done_cnt = 0; err_cnt = 0; pulse_bad = 0; gap_err = 0; hold_err = 0;
    last_done_cyc = -1; rsp_i = 0;
  endtask

  task automatic run_read(input logic [31:0] addr, input int hold);
    int n;
    clear_logs();
    @(negedge CLK);
    rd_req = 1'b1; rd_addr = addr;
    @(negedge CLK);
    check("accept_busy", 32'(rd_busy), 32'd1);
    check("accept_cs_low", 32'(sd_cs_n), 32'd0);
    check("accept_no_start", 32'(xfer_start), 32'd0);
    check("accept_err_clr", 32'(err_code), 32'd0);
    if (hold == 0) rd_req = 1'b0;
    @(negedge CLK);
    check("first_start", 32'(xfer_start), 32'd1);
    check("first_tx", 32'(tx_byte), 32'h51);
    repeat (hold) @(negedge CLK);
    rd_req = 1'b0;
    n = 0;
    while (n < 20000 && done_cnt + err_cnt == 0) begin
      @(negedge CLK);
      n++;
    end
    check("complete_in_budget", 32'(done_cnt + err_cnt != 0), 32'd1);
    repeat (4) @(negedge CLK);
  endtask

  task automatic verify(input string name, input logic [31:0] addr);
    int code, n_x, n_d, bad;
    logic [7:0] ce [0:5];
    logic [7:0] e;
    predict(code, n_x, n_d);
    ce[0] = 8'h51; ce[1] = addr[31:24]; ce[2] = addr[23:16];
    ce[3] = addr[15:8]; ce[4] = addr[7:0]; ce[5] = 8'hFF;
    check({name, ":done_pulses"}, 32'(done_cnt), (code == 0) ? 32'd1 : 32'd0);
    check({name, ":err_pulses"}, 32'(err_cnt), (code != 0) ? 32'd1 : 32'd0);
    check({name, ":err_code"}, 32'(err_code), 32'(code));
    check({name, ":exchanges"}, 32'(tx_log.size()), 32'(n_x));
    bad = 0;
    for (int k = 0; k < tx_log.size(); k++) begin
      e = (k < 6) ? ce[k] : 8'hFF;
      if (tx_log[k] !== e) bad++;
    end
    check({name, ":tx_bytes_bad"}, 32'(bad), 32'd0);
    check({name, ":dout_count"}, 32'(dout_log.size()), 32'(n_d));
    bad = 0;
    for (int k = 0; k < dout_log.size(); k++) begin
      if (k >= exp_q.size() || dout_log[k] !== exp_q[k] || idx_log[k] !== 9'(k)) bad++;
    end
    check({name, ":payload_bad"}, 32'(bad), 32'd0);
    check({name, ":cs_high_after"}, 32'(sd_cs_n), 32'd1);
    check({name, ":busy_low_after"}, 32'(rd_busy), 32'd0);
    check({name, ":pulse_bad"}, 32'(pulse_bad), 32'd0);
    check({name, ":gap_err"}, 32'(gap_err), 32'd0);
    check({name, ":hold_err"}, 32'(hold_err), 32'd0);
  endtask

  initial begin : main
    int n, n0;
    logic [31:0] a;
    RST = 1'b1; init_end = 1'b0; rd_req = 1'b0; rd_addr = 32'd0;
    for (int k = 0; k < 1024; k++) resp[k] = 8'hFF;
    clear_logs();
    repeat (3) @(negedge CLK);
    check("rst_cs_n", 32'(sd_cs_n), 32'd1);
    check("rst_busy", 32'(rd_busy), 32'd0);
    check("rst_done", 32'(rd_done), 32'd0);
    check("rst_err", 32'(rd_err), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_xfer_start", 32'(xfer_start), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_idx", 32'(dout_idx), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'hFF);
    RST = 1'b0;
    @(negedge CLK);

    // Requests while initialisation is unfinished must be ignored.
    rd_req = 1'b1; rd_addr = 32'h1234;
    repeat (20) @(negedge CLK);
    check("gate_busy", 32'(rd_busy), 32'd0);
    check("gate_cs_n", 32'(sd_cs_n), 32'd1);
    check("gate_no_xfer", 32'(tx_log.size()), 32'd0);
    rd_req = 1'b0;
    init_end = 1'b1;
    @(negedge CLK);

    build(2, 8'h00, 5, 8'hFE, 1'b0, 1'b0);
    run_read(32'h0000_0010, 0);
    verify("nominal", 32'h0000_0010);

    a = 32'($urandom);
    build(0, 8'h00, 0, 8'hFE, 1'b1, 1'b0);
    run_read(a, 200);
    verify("req_held", a);

    a = 32'($urandom);
    build(1, 8'h04, 0, 8'hFE, 1'b1, 1'b0);
    run_read(a, 0);
    verify("r1_reject", a);

    a = 32'($urandom);
    build(12, 8'h00, 0, 8'hFE, 1'b1, 1'b0);
    run_read(a, 0);
    verify("r1_timeout", a);

    a = 32'($urandom);
    build(0, 8'h00, 0, 8'hFF, 1'b1, 1'b0);
    run_read(a, 0);
    verify("token_timeout", a);

    a = 32'($urandom);
    build(1, 8'h00, 3, 8'h0B, 1'b1, 1'b0);
    run_read(a, 0);
    verify("data_err_token", a);

    a = 32'($urandom);
    build(1, 8'h00, 2, 8'hFE, 1'b1, 1'b1);
    run_read(a, 0);
    verify("crc_corrupt", a);

    // Reset in the middle of the payload stream.
    build(0, 8'h00, 1, 8'hFE, 1'b0, 1'b0);
    clear_logs();
    @(negedge CLK);
    rd_req = 1'b1; rd_addr = 32'h55;
    @(negedge CLK);
    rd_req = 1'b0;
    n = 0;
    while (n < 20000 && !(dout_valid === 1'b1 && dout_idx === 9'd100)) begin
      @(negedge CLK);
      n++;
    end
    check("rst_mid_reached_idx100", 32'(n < 20000), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_cs_n", 32'(sd_cs_n), 32'd1);
    check("rst_mid_busy", 32'(rd_busy), 32'd0);
    check("rst_mid_dout_idx", 32'(dout_idx), 32'd0);
    check("rst_mid_tx_byte", 32'(tx_byte), 32'hFF);
    RST = 1'b0;
    n0 = tx_log.size();
    repeat (10) @(negedge CLK);
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check("rst_mid_no_err", 32'(err_cnt), 32'd0);
    check("rst_mid_idle_no_xfer", 32'(tx_log.size()), 32'(n0));
    check("rst_mid_cs_stays", 32'(sd_cs_n), 32'd1);

    for (int r = 0; r < 3; r++) begin
      a = 32'($urandom);
      build($urandom_range(0, 5), 8'h00, $urandom_range(0, 10), 8'hFE, 1'b1, 1'b0);
      run_read(a, 0);
      verify((r == 0) ? "after_reset" : "random_read", a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
